de_write_buffer: RTL and testbench
==================================

# de_write_buffer

Posted-write buffer between the drawing engine's `de_*` port and the shared framebuffer memory port. It accepts the engine's single-word writes in at most one cycle each, queues them in a small FIFO, and drains them to memory whenever the memory arbiter grants. It also forwards engine reads in order behind any queued writes, so a drawing function is no longer throttled by arbitration latency against display refresh.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk` in 1, system clock, all state on rising edge
- `reset` in 1, asynchronous, active-high
- `de_req` in 1, engine request; held high until it samples `de_ack`
- `de_ack` out 1, one-cycle accept pulse; engine advances on the edge where it is high
- `de_addr` in 18, word address
- `de_nbyte` in 4, active-low byte enables; bit i covers `w_data[8i+7:8i]`
- `de_rnw` in 1, 1 = read, 0 = write
- `de_w_data` in 32, write data
- `de_r_data` out 32, read data, valid while `de_ack` is high for a read
- `mem_req` out 1, memory request, registered
- `mem_gnt` in 1, one-cycle grant; completes the presented transfer
- `mem_addr` out 18, `mem_nbyte` out 4, `mem_rnw` out 1, `mem_w_data` out 32: presented transfer
- `mem_r_data` in 32, read data, valid in the `mem_gnt` cycle
- `busy` out 1, high when `count != 0` or state != IDLE

## Operation
- FIFO of {addr, nbyte, data}, head/tail pointers wrap modulo DEPTH, `count` 0..DEPTH.
- Write accept: `de_ack = de_req & !de_rnw & (count < DEPTH)`, combinational. Accepted entries are pushed at the clock edge. When full, `de_ack` stays low and the request is held.
- Read accept: a read is only presented to memory when `count == 0` and state is IDLE. This preserves read-after-write ordering.
- States:
  - IDLE: if `count > 0`, go to WR. Else if `de_req & de_rnw`, latch `de_addr` and `de_nbyte`, then go to RD.
  - WR: `mem_req` = 1 and `mem_*` = head entry with `mem_rnw` = 0. On `mem_gnt`, pop. Stay in WR if the post-pop count is > 0, else go to IDLE.
  - RD: `mem_req` = 1 and `mem_*` = latched read with `mem_rnw` = 0→1. On `mem_gnt`: `de_ack` = 1, `de_r_data` = `mem_r_data` (combinational pass-through), go to IDLE.
- A push and a pop in the same cycle leave `count` unchanged. A push while full and popping is refused, because fullness is judged on the pre-edge count.
- `mem_w_data` is zero when `mem_rnw` = 1. `de_r_data` is zero outside a read ack.
- Reset mid-operation clears the FIFO and discards queued writes. It drops `mem_req` immediately. A grant arriving during reset is ignored.

## Timing
- Reset values: `de_ack` 0, `de_r_data` 0, `mem_req` 0, `mem_addr` 0, `mem_nbyte` 4'hF, `mem_rnw` 0, `mem_w_data` 0, `busy` 0.
- Write: accepted in the request cycle N. `mem_req` rises at N+1 if the FIFO was empty.
- Back-to-back writes are sustained at 1 per cycle until full. Drain is 1 per `mem_gnt`, with no idle cycle between entries.
- Read with an empty FIFO: request at N, RD from N+1, `de_ack` in the grant cycle. Minimum latency is 2 cycles.
- Read with k queued writes: `de_ack` no earlier than one cycle after the k-th write grant.

## Configuration
- `DE_WBUF_MERGE_EN` defined: a write whose `de_addr` equals the tail entry's address, with `count ≥ 2`, merges into the tail instead of pushing. The tail is never the entry on the bus.
  - Merge: enabled lanes overwrite data bytes, and `nbyte_tail &= de_nbyte`.
  - A merge is acked even when full.
- Not defined: every write pushes a new entry, and no address compare logic is built.

## Test plan
- Empty, single write of addr 0x00A0, nbyte 4'b1110, data 0x11223344 → `de_ack` in the same cycle; `mem_req` next cycle with the identical fields; `busy` drops the cycle after the grant.
- Grant held low, DEPTH+1 consecutive writes → first DEPTH acked one per cycle; last held without ack until the first `mem_gnt`, then acked; memory order matches issue order.
- Two queued writes, then a read of addr 0x0005 → read reaches memory only after both write grants; `de_r_data` = `mem_r_data` (0xCAFEF00D) during its one-cycle `de_ack`.
- `mem_gnt` tied high, continuous write stream → one write accepted and one drained per cycle; `count` never exceeds 1.
- Reset pulsed with 3 entries queued and `mem_req` high → `mem_req` low asynchronously; no queued write appears after reset releases.
- With `DE_WBUF_MERGE_EN`: entries {0x10,…}, {0x20, nbyte 4'b1100, data 0x0000AABB}, then 0x20 with nbyte 4'b0011, data 0xCCDD0000 → single memory write at 0x20, nbyte 4'b0000, data 0xCCDDAABB.

Source files
------------

// File: rtl/de_write_buffer.sv
// Posted-write buffer between the drawing engine port and the shared framebuffer memory port.
// Optional define DE_WBUF_MERGE_EN merges a same-address write into the FIFO tail entry.
module de_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        de_req_i,
    output logic        de_ack_o,
    input  logic [17:0] de_addr_i,
    input  logic [3:0]  de_nbyte_i,
    input  logic        de_rnw_i,
    input  logic [31:0] de_w_data_i,
    output logic [31:0] de_r_data_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [17:0] mem_addr_o,
    output logic [3:0]  mem_nbyte_o,
    output logic        mem_rnw_o,
    output logic [31:0] mem_w_data_o,
    input  logic [31:0] mem_r_data_i,
    output logic        busy_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD} state_e;

    state_e        state_q;
    logic          mem_req_q;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    logic [17:0]   rd_addr_q;
    logic [3:0]    rd_nbyte_q;

    logic [17:0]   addr_q  [DEPTH];
    logic [3:0]    nbyte_q [DEPTH];
    logic [31:0]   data_q  [DEPTH];

    logic wr_req, merge, wr_ack, push, pop, rd_done;

    assign wr_req  = de_req_i & ~de_rnw_i;
`ifdef DE_WBUF_MERGE_EN
    logic [PW-1:0] tail_last;
    assign tail_last = tail_q - PW'(1);
    // count >= 2 guarantees the tail is not the head entry currently on the bus
    assign merge = wr_req && (count_q >= CW'(2)) && (addr_q[tail_last] == de_addr_i);
`else
    assign merge = 1'b0;
`endif
    assign wr_ack  = wr_req & ((count_q < DEPTH_C) | merge);
    assign push    = wr_ack & ~merge;
    assign pop     = (state_q == WR) & mem_gnt_i;
    assign rd_done = (state_q == RD) & mem_gnt_i;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q]  <= de_addr_i;
            nbyte_q[tail_q] <= de_nbyte_i;
            data_q[tail_q]  <= de_w_data_i;
        end
`ifdef DE_WBUF_MERGE_EN
        if (merge) begin
            nbyte_q[tail_last] <= nbyte_q[tail_last] & de_nbyte_i;
            for (int i = 0; i < 4; i++) begin
                if (!de_nbyte_i[i]) data_q[tail_last][8*i +: 8] <= de_w_data_i[8*i +: 8];
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_addr_q  <= '0;
            rd_nbyte_q <= 4'hF;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    // A write being accepted this cycle starts the drain on the next one
                    if ((count_q != '0) || push) begin
                        state_q   <= WR;
                        mem_req_q <= 1'b1;
                    end else if (de_req_i && de_rnw_i) begin
                        rd_addr_q  <= de_addr_i;
                        rd_nbyte_q <= de_nbyte_i;
                        state_q    <= RD;
                        mem_req_q  <= 1'b1;
                    end
                end
                WR: begin
                    if (pop && (count_d == '0)) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                RD: begin
                    if (mem_gnt_i) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr_o   = '0;
        mem_nbyte_o  = 4'hF;
        mem_rnw_o    = 1'b0;
        mem_w_data_o = '0;
        case (state_q)
            WR: begin
                mem_addr_o   = addr_q[head_q];
                mem_nbyte_o  = nbyte_q[head_q];
                mem_w_data_o = data_q[head_q];
            end
            RD: begin
                mem_addr_o  = rd_addr_q;
                mem_nbyte_o = rd_nbyte_q;
                mem_rnw_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_req_o   = mem_req_q;
    assign de_ack_o    = wr_ack | rd_done;
    assign de_r_data_o = rd_done ? mem_r_data_i : '0;
    assign busy_o      = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_de_write_buffer.sv
// Directed bench for de_write_buffer: memory transfers are checked in order against a scoreboard queue.
module tb_de_write_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        de_req, de_ack, de_rnw, mem_req, mem_gnt, mem_rnw, busy;
    logic [17:0] de_addr, mem_addr;
    logic [3:0]  de_nbyte, mem_nbyte;
    logic [31:0] de_w_data, de_r_data, mem_w_data, mem_r_data;

    int checks = 0;
    int failures = 0;
    logic [54:0] exp_q[$];

`ifdef DE_WBUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    always #5 clk = ~clk;

    de_write_buffer #(.DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .de_req_i(de_req), .de_ack_o(de_ack), .de_addr_i(de_addr), .de_nbyte_i(de_nbyte),
        .de_rnw_i(de_rnw), .de_w_data_i(de_w_data), .de_r_data_o(de_r_data),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_nbyte_o(mem_nbyte),
        .mem_rnw_o(mem_rnw), .mem_w_data_o(mem_w_data), .mem_r_data_i(mem_r_data),
        .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [54:0] ent(input logic rnw, input logic [17:0] a,
                                        input logic [3:0] nb, input logic [31:0] d);
        return {rnw, a, nb, d};
    endfunction

    // Scoreboard: every granted memory transfer must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL mem_unexpected observed=%0h expected=none",
                       {mem_rnw, mem_addr, mem_nbyte, mem_w_data});
            end else begin
                chk("mem_xfer", {mem_rnw, mem_addr, mem_nbyte, mem_w_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wr(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d,
                      input string tag, input bit push_exp);
        cyc();
        de_req = 1'b1; de_rnw = 1'b0; de_addr = a; de_nbyte = nb; de_w_data = d;
        smp();
        chk(tag, de_ack, 1'b1);
        if (de_ack && push_exp) exp_q.push_back(ent(1'b0, a, nb, d));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        cyc();
        de_req = 1'b0; mem_gnt = 1'b1;
        smp();
        while (busy && n < 40) begin
            cyc();
            smp();
            n++;
        end
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        cyc();
        mem_gnt = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_nbyte = 4'hF;
        de_w_data = '0; mem_gnt = 1'b0; mem_r_data = 32'hCAFEF00D;
        smp();
        chk("rst_de_ack", de_ack, 1'b0);
        chk("rst_de_r_data", de_r_data, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 18'h0);
        chk("rst_mem_nbyte", mem_nbyte, 4'hF);
        chk("rst_mem_rnw", mem_rnw, 1'b0);
        chk("rst_mem_w_data", mem_w_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        cyc();
        reset = 1'b0;

        // Single write into an empty buffer
        wr(18'h000A0, 4'b1110, 32'h11223344, "t1_ack", 1'b1);
        chk("t1_mem_req_same_cycle", mem_req, 1'b0);
        cyc();
        de_req = 1'b0;
        smp();
        chk("t1_mem_req_next", mem_req, 1'b1);
        chk("t1_mem_addr", mem_addr, 18'h000A0);
        chk("t1_mem_nbyte", mem_nbyte, 4'b1110);
        chk("t1_mem_w_data", mem_w_data, 32'h11223344);
        chk("t1_mem_rnw", mem_rnw, 1'b0);
        chk("t1_busy", busy, 1'b1);
        cyc();
        mem_gnt = 1'b1;
        smp();
        cyc();
        mem_gnt = 1'b0;
        smp();
        chk("t1_busy_after_gnt", busy, 1'b0);
        chk("t1_mem_req_after_gnt", mem_req, 1'b0);

        // DEPTH+1 writes with grant held low
        for (int i = 0; i < 4; i++)
            wr(18'h00100 + 18'(i), 4'h0, 32'hA0000000 + 32'(i), "t2_ack", 1'b1);
        cyc();
        de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00104; de_nbyte = 4'h0; de_w_data = 32'hA0000004;
        smp();
        chk("t2_full_noack0", de_ack, 1'b0);
        cyc();
        smp();
        chk("t2_full_noack1", de_ack, 1'b0);
        cyc();
        mem_gnt = 1'b1;
        smp();
        chk("t2_full_gnt_cycle", de_ack, 1'b0);
        cyc();
        smp();
        chk("t2_ack_after_gnt", de_ack, 1'b1);
        if (de_ack) exp_q.push_back(ent(1'b0, 18'h00104, 4'h0, 32'hA0000004));
        drain("t2");

        // Read queued behind two writes
        wr(18'h00200, 4'h0, 32'h11111111, "t3_wr0", 1'b1);
        wr(18'h00201, 4'h3, 32'h22222222, "t3_wr1", 1'b1);
        cyc();
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00005; de_nbyte = 4'h0;
        exp_q.push_back(ent(1'b1, 18'h00005, 4'h0, 32'h0));
        smp();
        chk("t3_no_early_ack", de_ack, 1'b0);
        cyc();
        mem_gnt = 1'b1;
        smp();
        n = 0;
        while (!de_ack && n < 20) begin
            cyc();
            smp();
            n++;
        end
        chk("t3_rd_ack", de_ack, 1'b1);
        chk("t3_rd_data", de_r_data, 32'hCAFEF00D);
        chk("t3_ack_after_writes", n >= 2, 1'b1);
        cyc();
        de_req = 1'b0; de_rnw = 1'b0; mem_gnt = 1'b0;
        smp();
        chk("t3_ack_one_cycle", de_ack, 1'b0);
        chk("t3_r_data_zero", de_r_data, 32'h0);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Read with an empty buffer: minimum latency
        cyc();
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00123; de_nbyte = 4'b0101;
        exp_q.push_back(ent(1'b1, 18'h00123, 4'b0101, 32'h0));
        smp();
        chk("t3b_ack_req_cycle", de_ack, 1'b0);
        chk("t3b_mem_req_req_cycle", mem_req, 1'b0);
        cyc();
        mem_gnt = 1'b1; mem_r_data = 32'h5A5A1234;
        smp();
        chk("t3b_mem_req", mem_req, 1'b1);
        chk("t3b_mem_rnw", mem_rnw, 1'b1);
        chk("t3b_mem_w_data_zero", mem_w_data, 32'h0);
        chk("t3b_ack", de_ack, 1'b1);
        chk("t3b_r_data", de_r_data, 32'h5A5A1234);
        cyc();
        de_req = 1'b0; de_rnw = 1'b0; mem_gnt = 1'b0; mem_r_data = 32'hCAFEF00D;
        smp();
        chk("t3b_busy", busy, 1'b0);

        // Grant tied high, continuous write stream
        mem_gnt = 1'b1;
        for (int i = 0; i < 6; i++)
            wr(18'h00300 + 18'(i), 4'(i), 32'hB0B00000 + 32'(i), "t4_ack", 1'b1);
        cyc();
        de_req = 1'b0;
        smp();
        chk("t4_busy_last", busy, 1'b1);
        cyc();
        smp();
        chk("t4_count_le1", busy, 1'b0);
        chk("t4_sb_empty", exp_q.size(), 0);
        mem_gnt = 1'b0;

        // Reset with three writes queued
        for (int i = 0; i < 3; i++)
            wr(18'h00400 + 18'(i), 4'h0, 32'hDEAD0000 + 32'(i), "t5_ack", 1'b0);
        cyc();
        de_req = 1'b0;
        smp();
        chk("t5_mem_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_mem_req_async", mem_req, 1'b0);
        chk("t5_busy_async", busy, 1'b0);
        chk("t5_mem_nbyte_async", mem_nbyte, 4'hF);
        mem_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t5_no_stale_req", mem_req, 1'b0);
            cyc();
        end
        mem_gnt = 1'b0;

        // Same-address write to the tail entry
        wr(18'h00010, 4'h0, 32'h01020304, "t6_a", 1'b1);
        wr(18'h00020, 4'b1100, 32'h0000AABB, "t6_b", !MERGE);
        wr(18'h00020, 4'b0011, 32'hCCDD0000, "t6_c", !MERGE);
        if (MERGE) exp_q.push_back(ent(1'b0, 18'h00020, 4'b0000, 32'hCCDDAABB));
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
